// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - RS(255,239) shared constants, GF(2^8) multiply and generator coefficients
// Purpose: field polynomial, code dimensions, encoder state type, the general
//          GF(2^8) multiply and the 16 generator coefficients g0..g15 of
//          g(x) = prod_{i=0..15} (x + alpha^i), alpha = 0x02.
// Ports:   none (package).
package rs_pkg;

   localparam logic [7:0] GF_POLY = 8'h1D;   // x^8 + x^4 + x^3 + x^2 + 1, x^8 term implicit
   localparam int         K       = 239;
   localparam int         NP      = 16;
   localparam int         N       = K + NP;

   typedef enum logic {
      DATA   = 1'b0,
      PARITY = 1'b1
   } enc_state_t;

   // Shift-and-add multiply; the constant multipliers reuse these exact equations.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ s;
         s = {s[6:0], 1'b0} ^ (s[7] ? GF_POLY : 8'h00);
      end
      return p;
   endfunction

   // Expands the product of (x + alpha^i) one root at a time; c[NP] stays 1 (monic).
   function automatic logic [8*NP-1:0] gen_g();
      logic [7:0]      c [0:NP];
      logic [7:0]      root;
      logic [8*NP-1:0] packed_g;
      for (int j = 0; j <= NP; j++) c[j] = 8'h00;
      c[0] = 8'h01;
      root = 8'h01;
      for (int i = 0; i < NP; i++) begin
         for (int j = NP; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
         c[0] = gf_mul(c[0], root);
         root = gf_mul(root, 8'h02);
      end
      for (int j = 0; j < NP; j++) packed_g[8*j +: 8] = c[j];
      return packed_g;
   endfunction

   localparam logic [8*NP-1:0] G_PACKED = gen_g();

   localparam logic [7:0] G [0:NP-1] = '{
      G_PACKED[  7:  0], G_PACKED[ 15:  8], G_PACKED[ 23: 16], G_PACKED[ 31: 24],
      G_PACKED[ 39: 32], G_PACKED[ 47: 40], G_PACKED[ 55: 48], G_PACKED[ 63: 56],
      G_PACKED[ 71: 64], G_PACKED[ 79: 72], G_PACKED[ 87: 80], G_PACKED[ 95: 88],
      G_PACKED[103: 96], G_PACKED[111:104], G_PACKED[119:112], G_PACKED[127:120]
   };

endpackage

// File: rtl/rsenc_lfsr_if.sv
// rtl/rsenc_lfsr_if.sv - message-in / codeword-out stream bundle for the RS encoder
// Purpose: groups the input byte stream and the output codeword stream.
// Signals: in_valid/in_ready/in_data   message byte handshake (source -> encoder)
//          out_valid/out_ready/out_data codeword byte handshake (encoder -> sink)
//          out_sop/out_eop              first / last byte of a codeword
// Modports: slave  = encoder side, master = source/sink side.
interface rsenc_lfsr_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_sop;
   logic       out_eop;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sop, out_eop
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sop, out_eop
   );

endinterface

// File: rtl/gf_mul_const.sv
// rtl/gf_mul_const.sv - GF(2^8) multiply by a constant coefficient
// Purpose: o_y = i_a * C over GF(2^8) mod 0x11D, purely combinational.
// Ports:   i_a  in  8  variable operand
//          o_y  out 8  product
module gf_mul_const
   import rs_pkg::*;
#(
   parameter logic [7:0] C = 8'h01
) (
   input  logic [7:0] i_a,
   output logic [7:0] o_y
);

   // C is constant, so synthesis collapses the general equations to an XOR net.
   assign o_y = gf_mul(i_a, C);

endmodule

// File: rtl/rsenc_lfsr.sv
// rtl/rsenc_lfsr.sv - systematic RS(255,239) encoder, LFSR parity over GF(2^8)
// Purpose: passes 239 message bytes through and appends parity p15..p0.
// Ports:   clk   in  1  rising-edge clock
//          clrn  in  1  asynchronous active-low reset
//          bus   slave modport of rsenc_lfsr_if (in_* message stream,
//                out_* codeword stream with out_sop/out_eop)
module rsenc_lfsr
   import rs_pkg::*;
(
   input  logic         clk,
   input  logic         clrn,
   rsenc_lfsr_if.slave  bus
);

   enc_state_t r_state;
   logic [7:0] r_par [0:NP-1];
   logic [7:0] r_cnt;
   logic [7:0] r_out_data;
   logic       r_out_valid;
   logic       r_out_sop;
   logic       r_out_eop;

   logic       w_slot_free;
   logic       w_in_ready;
   logic [7:0] w_fb;
   logic [7:0] w_fbg [0:NP-1];

   // The single output register may load whenever it is empty or being drained.
   assign w_slot_free = !r_out_valid || bus.out_ready;
   assign w_in_ready  = (r_state == DATA) && w_slot_free;
   assign w_fb        = bus.in_data ^ r_par[NP-1];

   for (genvar j = 0; j < NP; j++) begin : g_mul
      gf_mul_const #(.C(G[j])) u_mul (
         .i_a (w_fb),
         .o_y (w_fbg[j])
      );
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state     <= DATA;
         r_cnt       <= 8'd0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         for (int j = 0; j < NP; j++) r_par[j] <= 8'h00;
      end else if (w_slot_free) begin
         // Slot is being vacated; stays empty unless something loads below.
         r_out_valid <= 1'b0;
         r_out_sop   <= 1'b0;
         r_out_eop   <= 1'b0;
         case (r_state)
            DATA: begin
               if (bus.in_valid) begin
                  r_par[0] <= w_fbg[0];
                  for (int j = 1; j < NP; j++) r_par[j] <= r_par[j-1] ^ w_fbg[j];
                  r_out_data  <= bus.in_data;
                  r_out_valid <= 1'b1;
                  r_out_sop   <= (r_cnt == 8'd0);
                  if (r_cnt == 8'(K-1)) begin
                     r_cnt   <= 8'd0;
                     r_state <= PARITY;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end
            end
            PARITY: begin
               // After NP shifts every parity register has drained to zero,
               // so the next codeword starts from a clean LFSR.
               r_out_data  <= r_par[NP-1];
               r_out_valid <= 1'b1;
               r_par[0]    <= 8'h00;
               for (int j = 1; j < NP; j++) r_par[j] <= r_par[j-1];
               if (r_cnt == 8'(NP-1)) begin
                  r_out_eop <= 1'b1;
                  r_cnt     <= 8'd0;
                  r_state   <= DATA;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sop   = r_out_sop;
   assign bus.out_eop   = r_out_eop;

endmodule
